alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU interface: accepts one DLX instruction plus register operands per transaction, decodes it, drives the ALU control/operand bus, and waits the fixed ALU latency.
- Captures aluout/carry and returns the result with rd over a valid/ready handshake.
- Sits in the execute stage between operand fetch and writeback.

---
 rtl/alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage issue controller for the DLX ALU.
// It decodes one instruction per transaction and drives the ALU operand and control bus.
// It waits ALU_LATENCY cycles and then returns the captured result over a valid/ready handshake.
// Optional build macro: ALU_ISSUE_CNT_EN adds the issue_count and illegal_count statistics outputs.
module alu_issue_ctrl #(
    parameter int unsigned ALU_LATENCY = 1  // 1..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [2:0]  alu_operation,
    output logic [2:0]  alu_opselect,
    output logic [4:0]  alu_shift_number,
    output logic        alu_enable_arith,
    output logic        alu_enable_shift,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_carry,
    output logic [4:0]  res_rd,
    output logic        res_illegal
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [31:0] issue_count,
    output logic [31:0] illegal_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        is_shift_q;

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        dec_legal;
    logic        dec_shift;
    logic [2:0]  dec_op;
    logic [2:0]  dec_opsel;
    logic [4:0]  dec_shamt;
    logic [31:0] dec_in2;
    logic [4:0]  dec_rd;

    // The rs1 register field is resolved upstream; only its operand value arrives here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr[25:21];

    assign opcode = instr[31:26];
    assign func   = instr[5:0];

    // Instruction decode: operand 2 source, ALU control codes and destination register.
    always_comb begin
        dec_legal = 1'b0;
        dec_shift = 1'b0;
        dec_op    = 3'b000;
        dec_opsel = 3'b000;
        dec_shamt = 5'd0;
        dec_in2   = '0;
        dec_rd    = instr[20:16];
        if (opcode == 6'h00) begin
            dec_rd  = instr[15:11];
            dec_in2 = rs2_data;
            case (func)
                6'h20: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b000; end
                6'h22: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b001; end
                6'h24: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b010; end
                6'h25: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b011; end
                6'h26: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b100; end
                6'h04: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_opsel = 3'b000; dec_shamt = rs2_data[4:0]; end
                6'h06: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_opsel = 3'b001; dec_shamt = rs2_data[4:0]; end
                6'h07: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_opsel = 3'b010; dec_shamt = rs2_data[4:0]; end
                default: ;
            endcase
        end else begin
            case (opcode)
                6'h08: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b000; dec_in2 = {{16{instr[15]}}, instr[15:0]}; end
                6'h0A: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b001; dec_in2 = {{16{instr[15]}}, instr[15:0]}; end
                6'h0C: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b010; dec_in2 = {16'h0000, instr[15:0]}; end
                6'h0D: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b011; dec_in2 = {16'h0000, instr[15:0]}; end
                6'h0E: begin dec_legal = 1'b1; dec_opsel = 3'b001; dec_op = 3'b100; dec_in2 = {16'h0000, instr[15:0]}; end
                6'h14: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_opsel = 3'b000; dec_shamt = instr[4:0]; end
                6'h16: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_opsel = 3'b001; dec_shamt = instr[4:0]; end
                6'h17: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_opsel = 3'b010; dec_shamt = instr[4:0]; end
                default: ;
            endcase
        end
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, handshake outputs and the single-cycle enable pulse.
    always_comb begin
        state_nxt        = state;
        in_ready         = 1'b0;
        res_valid        = 1'b0;
        alu_enable_arith = 1'b0;
        alu_enable_shift = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = dec_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                alu_enable_arith = ~is_shift_q;
                alu_enable_shift = is_shift_q;
                state_nxt        = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/control latch at accept, latency countdown and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_in1          <= '0;
            alu_in2          <= '0;
            alu_operation    <= '0;
            alu_opselect     <= '0;
            alu_shift_number <= '0;
            is_shift_q       <= 1'b0;
            cnt              <= '0;
            res_data         <= '0;
            res_carry        <= 1'b0;
            res_rd           <= '0;
            res_illegal      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_in1          <= rs1_data;
                        alu_in2          <= dec_in2;
                        alu_operation    <= dec_op;
                        alu_opselect     <= dec_opsel;
                        alu_shift_number <= dec_shamt;
                        is_shift_q       <= dec_shift;
                        res_rd           <= dec_rd;
                        res_illegal      <= ~dec_legal;
                        if (!dec_legal) begin
                            res_data  <= '0;
                            res_carry <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= 3'(ALU_LATENCY - 1);
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        res_data  <= alu_out;
                        res_carry <= alu_carry;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    // Free-running statistics counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count   <= '0;
            illegal_count <= '0;
        end else begin
            if (state == ISSUE) begin
                issue_count <= issue_count + 32'd1;
            end
            if (state == IDLE && in_valid && !dec_legal) begin
                illegal_count <= illegal_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a behavioural one-cycle ALU model.
// Build with ALU_ISSUE_CNT_EN defined to also exercise the statistics counters.
module tb_alu_issue_ctrl;

    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] alu_in1, alu_in2;
    logic [2:0]  alu_operation, alu_opselect;
    logic [4:0]  alu_shift_number;
    logic        alu_enable_arith, alu_enable_shift;
    logic [31:0] alu_out = '0;
    logic        alu_carry = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_carry;
    logic [4:0]  res_rd;
    logic        res_illegal;
`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] issue_count, illegal_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.ALU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_operation(alu_operation),
        .alu_opselect(alu_opselect), .alu_shift_number(alu_shift_number),
        .alu_enable_arith(alu_enable_arith), .alu_enable_shift(alu_enable_shift),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_rd(res_rd), .res_illegal(res_illegal)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .issue_count(issue_count), .illegal_count(illegal_count)
`endif
    );

    // One-cycle ALU model: result registered on the enable pulse, held afterwards.
    always @(posedge clk) begin
        if (alu_enable_arith) begin
            case (alu_operation)
                3'b000:  {alu_carry, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
                3'b001:  {alu_carry, alu_out} <= {1'b0, alu_in1} - {1'b0, alu_in2};
                3'b010:  {alu_carry, alu_out} <= {1'b0, alu_in1 & alu_in2};
                3'b011:  {alu_carry, alu_out} <= {1'b0, alu_in1 | alu_in2};
                3'b100:  {alu_carry, alu_out} <= {1'b0, alu_in1 ^ alu_in2};
                default: {alu_carry, alu_out} <= '0;
            endcase
        end else if (alu_enable_shift) begin
            case (alu_opselect)
                3'b000:  {alu_carry, alu_out} <= {1'b0, alu_in1 << alu_shift_number};
                3'b001:  {alu_carry, alu_out} <= {1'b0, alu_in1 >> alu_shift_number};
                3'b010:  {alu_carry, alu_out} <= {1'b0, 32'($signed(alu_in1) >>> alu_shift_number)};
                default: {alu_carry, alu_out} <= '0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE and advance to the cycle after acceptance.
    task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        check("accept_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Called in the first WAIT cycle; counts edges until res_valid, bounded.
    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("hs_in_ready", 32'(in_ready), 32'd1);
        check("hs_res_valid", 32'(res_valid), 32'd0);
    endtask

    // Full legal transaction: issue-cycle bus, WAIT hold, result and handshake.
    task automatic do_op(input string tag, input logic [31:0] i, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ea, input logic es,
                         input logic [2:0] op, input logic [2:0] sel, input logic [4:0] sh,
                         input logic [31:0] in2, input logic [31:0] res, input logic c,
                         input logic [4:0] rd, input logic early);
        res_ready = early;
        send(i, r1, r2);
        check({tag, "_en"}, {30'd0, alu_enable_arith, alu_enable_shift}, {30'd0, ea, es});
        check({tag, "_op"}, 32'(alu_operation), 32'(op));
        check({tag, "_sel"}, 32'(alu_opselect), 32'(sel));
        check({tag, "_sh"}, 32'(alu_shift_number), 32'(sh));
        check({tag, "_in1"}, alu_in1, r1);
        check({tag, "_in2"}, alu_in2, in2);
        check({tag, "_rv_issue"}, 32'(res_valid), 32'd0);
        step();
        check({tag, "_wait_en"}, {30'd0, alu_enable_arith, alu_enable_shift}, 32'd0);
        check({tag, "_wait_in2"}, alu_in2, in2);
        check({tag, "_wait_rv"}, 32'(res_valid), 32'd0);
        wait_res();
        check({tag, "_data"}, res_data, res);
        check({tag, "_carry"}, 32'(res_carry), 32'(c));
        check({tag, "_rd"}, 32'(res_rd), 32'(rd));
        check({tag, "_illegal"}, 32'(res_illegal), 32'd0);
        handshake();
    endtask

    task automatic do_illegal(input string tag, input logic [31:0] i);
        send(i, 32'h1111_1111, 32'h2222_2222);
        check({tag, "_en"}, {30'd0, alu_enable_arith, alu_enable_shift}, 32'd0);
        check({tag, "_rv"}, 32'(res_valid), 32'd1);
        check({tag, "_illegal"}, 32'(res_illegal), 32'd1);
        check({tag, "_data"}, res_data, 32'd0);
        check({tag, "_carry"}, 32'(res_carry), 32'd0);
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_en", {30'd0, alu_enable_arith, alu_enable_shift}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_in1", alu_in1, 32'd0);
        check("rst_opsel", 32'(alu_opselect), 32'd0);
        check("rst_illegal", 32'(res_illegal), 32'd0);

        //     tag     instr         rs1           rs2    ea    es    op      sel     sh     in2           result        c     rd     early
        do_op("add",  32'h0000_1820, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 3'b000, 3'b001, 5'd0,  32'h0000_0001, 32'h0000_0000, 1'b1, 5'd3,  1'b0);
        do_op("addi", 32'h2004_FFFE, 32'd5,        32'd0, 1'b1, 1'b0, 3'b000, 3'b001, 5'd0,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 5'd4,  1'b0);
        do_op("ori",  32'h3407_8000, 32'h1234_0000, 32'd0, 1'b1, 1'b0, 3'b011, 3'b001, 5'd0,  32'h0000_8000, 32'h1234_8000, 1'b0, 5'd7,  1'b1);
        do_op("srai", 32'h5C09_001F, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 3'b000, 3'b010, 5'd31, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 5'd9,  1'b0);
        do_op("sll",  32'h0000_5004, 32'd1,        32'h23, 1'b0, 1'b1, 3'b000, 3'b000, 5'd3,  32'h0000_0023, 32'h0000_0008, 1'b0, 5'd10, 1'b0);
        do_op("sub",  32'h0000_0822, 32'd10,       32'd3, 1'b1, 1'b0, 3'b001, 3'b001, 5'd0,  32'h0000_0003, 32'h0000_0007, 1'b0, 5'd1,  1'b0);
        do_op("xori", 32'h3802_00FF, 32'hF0F0_F0F0, 32'd0, 1'b1, 1'b0, 3'b100, 3'b001, 5'd0,  32'h0000_00FF, 32'hF0F0_F00F, 1'b0, 5'd2,  1'b0);
        do_op("srl",  32'h0000_3006, 32'h8000_0000, 32'd4, 1'b0, 1'b1, 3'b000, 3'b001, 5'd4,  32'h0000_0004, 32'h0800_0000, 1'b0, 5'd6,  1'b0);

        // Backpressure: result held while a second instruction waits on in_valid.
        send(32'h0000_2820, 32'd2, 32'd3);
        step();
        wait_res();
        instr    = 32'h2004_FFFE;
        rs1_data = 32'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_data", res_data, 32'd5);
            check("bp_rd", 32'(res_rd), 32'd5);
            check("bp_flags", {29'd0, res_valid, in_ready, alu_enable_arith}, {29'd0, 3'b100});
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_idle", {30'd0, in_ready, res_valid}, {30'd0, 2'b10});
        step();
        in_valid = 1'b0;
        check("bp_next_en", 32'(alu_enable_arith), 32'd1);
        check("bp_next_in1", alu_in1, 32'd9);
        check("bp_next_in2", alu_in2, 32'hFFFF_FFFE);
        step();
        wait_res();
        check("bp_next_data", res_data, 32'd7);
        check("bp_next_carry", 32'(res_carry), 32'd1);
        handshake();

        do_illegal("ill_op3f", 32'hFC00_0000);
        do_illegal("ill_func", 32'h0000_003F);
`ifdef ALU_ISSUE_CNT_EN
        check("cnt_issue", issue_count, 32'd10);
        check("cnt_illegal", illegal_count, 32'd2);
`endif

        // Reset during WAIT drops the operation; no stale result may surface.
        send(32'h0000_0820, 32'd4, 32'd4);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("wrst_in_ready", 32'(in_ready), 32'd1);
        check("wrst_res_valid", 32'(res_valid), 32'd0);
        check("wrst_en", {30'd0, alu_enable_arith, alu_enable_shift}, 32'd0);
        check("wrst_res_data", res_data, 32'd0);
`ifdef ALU_ISSUE_CNT_EN
        check("wrst_cnt", issue_count | illegal_count, 32'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            check("wrst_no_stale", {30'd0, res_valid, in_ready}, {30'd0, 2'b01});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
